mips32_prog_loader: RTL and testbench

Streaming program loader that sits directly upstream of the pipelined MIPS32 core. It accepts 32-bit instruction words over a valid/ready handshake, writes them into the core's unified memory from address 0 upward, and detects the HALT opcode as end-of-image. Once the image is loaded, it releases the core with PC = 0. This replaces bench-side direct pokes of `Mem[]`, `PC` and `HALTED`.

---
 rtl/mips32_prog_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_mips32_prog_loader.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_prog_loader.sv
// ---------------------------------------------------------------------------
// mips32_prog_loader
//
// Streaming program loader placed in front of the pipelined MIPS32 core.
// Host instruction words arrive over a valid/ready handshake and are written
// into the core's unified memory from word address 0 upward. A word whose
// opcode field (word[31:26]) equals HALT_OP marks the end of the image, after
// which the core is released (proc_run) and observed until it halts.
//
// Optional feature macro: MIPS32_LOADER_CHECKSUM_EN
//   When defined, the image must be followed by one extra host word equal to
//   the 32-bit wrapping sum of all written words (HALT included). That word
//   is not written to memory. A match releases the core, a mismatch errors.
//
// Parameters:
//   ADDR_W   memory word-address width (capacity 2^ADDR_W words)
//   HALT_OP  opcode that terminates the image
//
// Ports:
//   clk1         clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        single-cycle load request (honoured in IDLE/DONE/ERROR)
//   in_valid     host word valid
//   in_data      host instruction word
//   in_ready     loader accepts a word this cycle (registered state decode)
//   mem_we       memory write strobe, one cycle per accepted word
//   mem_addr     memory word address
//   mem_wdata    memory write data
//   proc_halted  core HALTED flag
//   proc_run     core enable; core holds PC/TAKEN_BRANCH cleared while low
//   busy         loader is in LOAD or CHECK
//   done         sticky: program ran to HALT
//   error        sticky: overflow or checksum mismatch
//   word_count   words written in the current load (saturates at 2^ADDR_W)
// ---------------------------------------------------------------------------
module mips32_prog_loader #(
  parameter int unsigned ADDR_W  = 10,
  parameter logic [5:0]  HALT_OP = 6'h3f
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              proc_halted,
  output logic              proc_run,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef MIPS32_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WC_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   WC_MAX  = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_word_count;
  logic                r_in_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_proc_run;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
`ifdef MIPS32_LOADER_CHECKSUM_EN
  logic [31:0]         r_cksum;
`endif

  logic                w_hs;
  logic                w_is_halt;
  logic                w_ptr_last;
  logic [ADDR_W:0]     w_wc_next;

  always_comb begin
    w_hs       = in_valid & r_in_ready;
    w_is_halt  = (in_data[31:26] == HALT_OP);
    w_ptr_last = (r_ptr == '1);
    w_wc_next  = (r_word_count == WC_MAX) ? r_word_count : r_word_count + WC_ONE;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_word_count <= '0;
      r_in_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_proc_run   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
      r_cksum      <= '0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_ptr        <= '0;
          r_word_count <= '0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
          r_cksum      <= '0;
`endif
          if (start) begin
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        S_LOAD: begin
          if (w_hs) begin
            r_mem_we     <= 1'b1;
            r_mem_addr   <= r_ptr;
            r_mem_wdata  <= in_data;
            r_ptr        <= r_ptr + PTR_ONE;
            r_word_count <= w_wc_next;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            r_cksum      <= r_cksum + in_data;
`endif
            if (w_is_halt) begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
              r_state    <= S_CHECK;
`else
              r_state    <= S_RUN;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
`endif
            end else if (w_ptr_last) begin
              // Last slot filled without HALT: the word is kept, load aborts.
              r_state    <= S_ERROR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_error    <= 1'b1;
            end
          end
        end

`ifdef MIPS32_LOADER_CHECKSUM_EN
        S_CHECK: begin
          // Trailing checksum word is consumed but never written.
          if (w_hs) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (in_data == r_cksum) begin
              r_state <= S_RUN;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif

        S_RUN: begin
          // One cycle with proc_run low after entry lets the final memory
          // write land first; proc_halted is only trusted once the core runs.
          if (!r_proc_run) begin
            r_proc_run <= 1'b1;
          end else if (proc_halted) begin
            r_proc_run <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end

        S_DONE, S_ERROR: begin
          if (start) begin
            r_state      <= S_LOAD;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_ptr        <= '0;
            r_word_count <= '0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            r_cksum      <= '0;
`endif
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_proc_run <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign proc_run   = r_proc_run;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// ---------------------------------------------------------------------------
// Testbench for mips32_prog_loader.
// Two instances: a full-size loader (ADDR_W=10) for image streaming, reset
// and start-ignore scenarios, and a tiny one (ADDR_W=3) for the capacity
// boundary. Images are random instruction words ending with a HALT word;
// expected writes are image[i] at address i, expected counts come from the
// image length and capacity, and the checksum is the plain sum of the image.
// ---------------------------------------------------------------------------
module tb_mips32_prog_loader;

  localparam int unsigned AW  = 10;
  localparam int unsigned SAW = 3;

  logic          clk1 = 1'b0;
  logic          rst_n;

  logic          start, in_valid, proc_halted;
  logic [31:0]   in_data;
  logic          in_ready, mem_we, proc_run, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;

  logic           s_start, s_in_valid, s_proc_halted;
  logic [31:0]    s_in_data;
  logic           s_in_ready, s_mem_we, s_proc_run, s_busy, s_done, s_error;
  logic [SAW-1:0] s_mem_addr;
  logic [31:0]    s_mem_wdata;
  logic [SAW:0]   s_word_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] img[$];

  always #5 clk1 = ~clk1;

  mips32_prog_loader #(.ADDR_W(AW), .HALT_OP(6'h3f)) u_dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .proc_halted(proc_halted),
    .proc_run(proc_run), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  mips32_prog_loader #(.ADDR_W(SAW), .HALT_OP(6'h3f)) u_small (
    .clk1(clk1), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid),
    .in_data(s_in_data), .in_ready(s_in_ready), .mem_we(s_mem_we),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .proc_halted(s_proc_halted),
    .proc_run(s_proc_run), .busy(s_busy), .done(s_done), .error(s_error),
    .word_count(s_word_count)
  );

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3f) w[31:26] = 6'h08;
    return w;
  endfunction

  task automatic make_image(input int n, input logic [31:0] halt_word);
    img.delete();
    for (int i = 0; i < n - 1; i++) img.push_back(rand_word());
    img.push_back(halt_word);
  endtask

`ifdef MIPS32_LOADER_CHECKSUM_EN
  function automatic logic [31:0] model_sum();
    logic [31:0] s;
    s = '0;
    foreach (img[i]) s = s + img[i];
    return s;
  endfunction
`endif

  // Pulse start on the main loader and confirm it entered a fresh load.
  task automatic start_main(input string tag);
    @(negedge clk1); start = 1'b1;
    @(posedge clk1); #1; start = 1'b0;
    checks++;
    if ({busy, in_ready, done, error, proc_run} !== 5'b11000 || word_count !== '0) begin
      errors++;
      $display("FAIL %s_start: busy/rdy/done/err/run=%b wc=%0d expected 11000 wc=0",
               tag, {busy, in_ready, done, error, proc_run}, word_count);
    end
  endtask

  // Stream img[0..max_words-1]; gap 0=always valid, 1=one in three, 2=random.
  task automatic stream_main(input string tag, input int gap, input int start_at,
                             input int max_words);
    int   idx;
    int   cyc;
    int   budget;
    logic v;
    logic hs;
    idx = 0; cyc = 0; budget = 4 * max_words + 20;
    while (idx < max_words && cyc < budget) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk1);
      in_valid = v;
      in_data  = v ? img[idx] : $urandom;
      start    = v && (idx == start_at);
      hs       = v && in_ready;
      @(posedge clk1); #1;
      start = 1'b0;
      checks++;
      if (hs) begin
        if (mem_we !== 1'b1 || mem_addr !== idx[AW-1:0] || mem_wdata !== img[idx]) begin
          errors++;
          $display("FAIL %s_write: we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                   tag, mem_we, mem_addr, mem_wdata, idx, img[idx]);
        end
        idx++;
        checks++;
        if (word_count !== (AW+1)'(idx)) begin
          errors++;
          $display("FAIL %s_count: word_count=%0d expected %0d", tag, word_count, idx);
        end
      end else if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL %s_idle_we: mem_we=%b expected 0 (no handshake)", tag, mem_we);
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != max_words) begin
      errors++;
      $display("FAIL %s_timeout: accepted %0d words expected %0d", tag, idx, max_words);
    end
  endtask

  // From just after the HALT handshake up to proc_run high.
  task automatic enter_run(input string tag);
`ifdef MIPS32_LOADER_CHECKSUM_EN
    checks++;
    if ({in_ready, busy, proc_run} !== 3'b110) begin
      errors++;
      $display("FAIL %s_check_state: rdy/busy/run=%b expected 110", tag, {in_ready, busy, proc_run});
    end
    @(negedge clk1); in_valid = 1'b1; in_data = model_sum();
    @(posedge clk1); #1; in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL %s_cksum_nowrite: mem_we=%b expected 0", tag, mem_we);
    end
`endif
    checks++;
    if ({in_ready, busy, proc_run, done, error} !== 5'b0) begin
      errors++;
      $display("FAIL %s_post_halt: rdy/busy/run/done/err=%b expected 00000",
               tag, {in_ready, busy, proc_run, done, error});
    end
    @(posedge clk1); #1;
    checks++;
    if (proc_run !== 1'b1) begin
      errors++;
      $display("FAIL %s_run_rise: proc_run=%b expected 1", tag, proc_run);
    end
  endtask

  // In RUN: start must be ignored, then the core halts.
  task automatic halt_run(input string tag);
    @(negedge clk1); start = 1'b1;
    @(posedge clk1); #1; start = 1'b0;
    checks++;
    if ({proc_run, busy, done} !== 3'b100 || word_count !== (AW+1)'(img.size())) begin
      errors++;
      $display("FAIL %s_start_in_run: run/busy/done=%b wc=%0d expected 100 wc=%0d",
               tag, {proc_run, busy, done}, word_count, img.size());
    end
    repeat ($urandom_range(0, 4)) @(posedge clk1);
    @(negedge clk1); proc_halted = 1'b1;
    @(posedge clk1); #1; proc_halted = 1'b0;
    checks++;
    if ({proc_run, done, error, busy} !== 4'b0100) begin
      errors++;
      $display("FAIL %s_halt: run/done/err/busy=%b expected 0100", tag, {proc_run, done, error, busy});
    end
    @(posedge clk1); #1;
    checks++;
    if (done !== 1'b1 || proc_run !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_sticky: done=%b run=%b expected 1 0", tag, done, proc_run);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({in_ready, mem_we, proc_run, busy, done, error, mem_addr, mem_wdata, word_count} !== '0) begin
      errors++;
      $display("FAIL reset_main: outputs=%h expected 0",
               {in_ready, mem_we, proc_run, busy, done, error, mem_addr, mem_wdata, word_count});
    end
    start = 1'b1; s_start = 1'b1;
    @(posedge clk1); #1;
    checks++;
    if ({s_in_ready, s_mem_we, s_proc_run, s_busy, s_done, s_error, s_mem_addr, s_mem_wdata,
         s_word_count, busy, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs nonzero with start during reset");
    end
    start = 1'b0; s_start = 1'b0;
    @(negedge clk1); rst_n = 1'b1;
    @(posedge clk1); #1;
    checks++;
    if ({busy, in_ready, word_count} !== '0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b rdy=%b wc=%0d expected 0 0 0", busy, in_ready, word_count);
    end
  endtask

  task automatic test_stream_full();
    make_image(18, 32'hfc000000);
    start_main("full");
    stream_main("full", 0, -1, 18);
    enter_run("full");
    halt_run("full");
  endtask

  task automatic test_gappy();
    make_image(18, 32'hfc000000);
    start_main("gap");
    stream_main("gap", 1, -1, 18);
    enter_run("gap");
    halt_run("gap");
  endtask

  task automatic test_back_to_back();
    int n;
    n = $urandom_range(6, 30);
    make_image(n, {6'h3f, 26'($urandom)});
    start_main("b2b");
    stream_main("b2b", 2, n / 2, n);
    enter_run("b2b");
    halt_run("b2b");
  endtask

  task automatic test_reset_midload();
    make_image(18, 32'hfc000000);
    start_main("rstl");
    stream_main("rstl", 0, -1, 5);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_we, proc_run, busy, done, error, mem_addr, mem_wdata, word_count} !== '0) begin
      errors++;
      $display("FAIL rstl_async: outputs=%h expected 0",
               {in_ready, mem_we, proc_run, busy, done, error, mem_addr, mem_wdata, word_count});
    end
    @(negedge clk1); rst_n = 1'b1;
    start_main("rstl2");
    stream_main("rstl2", 0, -1, 18);
    enter_run("rstl2");
    halt_run("rstl2");
  endtask

  task automatic test_reset_midrun();
    make_image($urandom_range(3, 10), {6'h3f, 26'($urandom)});
    start_main("rstr");
    stream_main("rstr", 2, -1, img.size());
    enter_run("rstr");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({proc_run, done, busy, word_count} !== '0) begin
      errors++;
      $display("FAIL rstr_async: run=%b done=%b busy=%b wc=%0d expected all 0",
               proc_run, done, busy, word_count);
    end
    @(negedge clk1); rst_n = 1'b1;
  endtask

  task automatic test_overflow();
    int          acc;
    int          exp_acc;
    logic        hs;
    logic        seen_run;
    logic [31:0] cur;
    acc = 0; seen_run = 1'b0; cur = rand_word();
    exp_acc = (9 < (1 << SAW)) ? 9 : (1 << SAW);
    @(negedge clk1); s_start = 1'b1;
    @(posedge clk1); #1; s_start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk1);
      s_in_valid = (acc < 9);
      s_in_data  = cur;
      hs = s_in_valid && s_in_ready;
      @(posedge clk1); #1;
      if (s_proc_run) seen_run = 1'b1;
      checks++;
      if (hs) begin
        if (s_mem_we !== 1'b1 || s_mem_addr !== acc[SAW-1:0] || s_mem_wdata !== cur) begin
          errors++;
          $display("FAIL ovf_write: we=%b addr=%0d data=%h expected 1 %0d %h",
                   s_mem_we, s_mem_addr, s_mem_wdata, acc, cur);
        end
        acc++;
        cur = rand_word();
      end else if (s_mem_we !== 1'b0) begin
        errors++;
        $display("FAIL ovf_idle_we: mem_we=%b expected 0", s_mem_we);
      end
    end
    s_in_valid = 1'b0;
    checks++;
    if (acc != exp_acc) begin
      errors++;
      $display("FAIL ovf_accepted: %0d words expected %0d", acc, exp_acc);
    end
    checks++;
    if ({s_error, s_in_ready, s_busy, s_proc_run, s_done} !== 5'b10000 ||
        s_word_count !== (SAW+1)'(exp_acc)) begin
      errors++;
      $display("FAIL ovf_state: err/rdy/busy/run/done=%b wc=%0d expected 10000 wc=%0d",
               {s_error, s_in_ready, s_busy, s_proc_run, s_done}, s_word_count, exp_acc);
    end
    checks++;
    if (seen_run !== 1'b0) begin
      errors++;
      $display("FAIL ovf_run: proc_run rose=%b expected 0", seen_run);
    end
  endtask

  // Image that exactly fills the small memory with HALT in the last slot.
  task automatic test_exact_fit();
    logic [31:0] simg[$];
    logic [31:0] sum;
    int          acc;
    int          cyc;
    logic        hs;
    for (int i = 0; i < (1 << SAW) - 1; i++) simg.push_back(rand_word());
    simg.push_back({6'h3f, 26'($urandom)});
    sum = '0;
    foreach (simg[i]) sum = sum + simg[i];
    @(negedge clk1); s_start = 1'b1;
    @(posedge clk1); #1; s_start = 1'b0;
    checks++;
    if ({s_error, s_busy, s_in_ready} !== 3'b011 || s_word_count !== '0) begin
      errors++;
      $display("FAIL fit_restart: err/busy/rdy=%b wc=%0d expected 011 wc=0",
               {s_error, s_busy, s_in_ready}, s_word_count);
    end
    acc = 0; cyc = 0;
    while (acc < simg.size() && cyc < 40) begin
      @(negedge clk1);
      s_in_valid = 1'b1; s_in_data = simg[acc];
      hs = s_in_ready;
      @(posedge clk1); #1;
      checks++;
      if (hs) begin
        if (s_mem_we !== 1'b1 || s_mem_addr !== acc[SAW-1:0] || s_mem_wdata !== simg[acc]) begin
          errors++;
          $display("FAIL fit_write: we=%b addr=%0d data=%h expected 1 %0d %h",
                   s_mem_we, s_mem_addr, s_mem_wdata, acc, simg[acc]);
        end
        acc++;
      end else if (s_mem_we !== 1'b0) begin
        errors++;
        $display("FAIL fit_idle_we: mem_we=%b expected 0", s_mem_we);
      end
      cyc++;
    end
    s_in_valid = 1'b0;
    checks++;
    if (acc != simg.size() || s_error !== 1'b0 || s_word_count !== (SAW+1)'(simg.size())) begin
      errors++;
      $display("FAIL fit_end: accepted=%0d err=%b wc=%0d expected %0d 0 %0d",
               acc, s_error, s_word_count, simg.size(), simg.size());
    end
`ifdef MIPS32_LOADER_CHECKSUM_EN
    @(negedge clk1); s_in_valid = 1'b1; s_in_data = sum;
    @(posedge clk1); #1; s_in_valid = 1'b0;
    checks++;
    if (s_mem_we !== 1'b0 || s_error !== 1'b0) begin
      errors++;
      $display("FAIL fit_cksum: we=%b err=%b expected 0 0", s_mem_we, s_error);
    end
`endif
    checks++;
    if ({s_in_ready, s_proc_run} !== 2'b00) begin
      errors++;
      $display("FAIL fit_post_halt: rdy/run=%b expected 00", {s_in_ready, s_proc_run});
    end
    @(posedge clk1); #1;
    checks++;
    if (s_proc_run !== 1'b1) begin
      errors++;
      $display("FAIL fit_run: proc_run=%b expected 1", s_proc_run);
    end
    @(negedge clk1); s_proc_halted = 1'b1;
    @(posedge clk1); #1; s_proc_halted = 1'b0;
    checks++;
    if ({s_proc_run, s_done} !== 2'b01) begin
      errors++;
      $display("FAIL fit_done: run/done=%b expected 01", {s_proc_run, s_done});
    end
  endtask

`ifdef MIPS32_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    make_image(18, 32'hfc000000);
    start_main("bad");
    stream_main("bad", 0, -1, 18);
    @(negedge clk1); in_valid = 1'b1; in_data = model_sum() + 32'd1;
    @(posedge clk1); #1; in_valid = 1'b0;
    checks++;
    if ({mem_we, error, proc_run, in_ready, busy} !== 5'b01000 || word_count !== (AW+1)'(18)) begin
      errors++;
      $display("FAIL bad_cksum: we/err/run/rdy/busy=%b wc=%0d expected 01000 wc=18",
               {mem_we, error, proc_run, in_ready, busy}, word_count);
    end
    repeat (3) @(posedge clk1);
    #1;
    checks++;
    if (proc_run !== 1'b0 || error !== 1'b1) begin
      errors++;
      $display("FAIL bad_sticky: run=%b err=%b expected 0 1", proc_run, error);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_data = '0; proc_halted = 1'b0;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_proc_halted = 1'b0;
    test_reset();
    test_stream_full();
    test_gappy();
    test_back_to_back();
    test_reset_midload();
    test_reset_midrun();
    test_overflow();
    test_exact_fit();
`ifdef MIPS32_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
